// File: rtl/cnn_frame_sequencer.sv
// Frame-level sequencer for the CNN classifier: streams one ROM image into conv1,
// tracks per-stage beat counts, waits for the argmax result and emits an ASCII letter.
module cnn_frame_sequencer #(
  parameter int IX          = 28,
  parameter int IY          = 28,
  parameter int I_F_BW      = 8,
  parameter int IMG_NUM     = 16,
  parameter int CONV1_BEATS = 576,
  parameter int POOL_BEATS  = 144,
  parameter int CONV2_BEATS = 64,
  parameter int CLS_BW      = 5,
  parameter int TIMEOUT     = 4096
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               i_start,
  input  logic [3:0]                         sw,
  output logic [$clog2(IMG_NUM*IX*IY)-1:0]   o_rom_addr,
  input  logic [I_F_BW-1:0]                  i_rom_data,
  output logic                               o_dp_clear,
  output logic                               o_pix_valid,
  output logic [I_F_BW-1:0]                  o_pixel,
  input  logic                               i_conv1_valid,
  input  logic                               i_pool_valid,
  input  logic                               i_conv2_valid,
  input  logic                               i_cls_valid,
  input  logic [CLS_BW-1:0]                  i_cls_idx,
  output logic                               o_busy,
  output logic                               out_valid,
  output logic [7:0]                         alpha,
  output logic                               o_error
);

  localparam int PIX_NUM = IX * IY;
  localparam int ADDR_W  = $clog2(IMG_NUM * IX * IY);
  localparam int PIX_W   = $clog2(PIX_NUM);
  localparam int C1_W    = $clog2(CONV1_BEATS + 1);
  localparam int PL_W    = $clog2(POOL_BEATS + 1);
  localparam int C2_W    = $clog2(CONV2_BEATS + 1);
  localparam int WD_W    = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_DRAIN,
    S_WAIT_CLS,
    S_DONE
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [3:0]          img_sel;
  logic [PIX_W-1:0]    pix_cnt;
  logic [ADDR_W-1:0]   rom_addr;
  logic                pix_valid;
  logic [C1_W-1:0]     conv1_cnt;
  logic [PL_W-1:0]     pool_cnt;
  logic [C2_W-1:0]     conv2_cnt;
  logic [WD_W-1:0]     wd_cnt;
  logic                error_q;
  logic                out_valid_q;
  logic [7:0]          alpha_q;

  logic counting;
  logic watching;
  logic any_valid;
  logic conv1_full;
  logic pool_full;
  logic conv2_full;
  logic last_pix;
  logic wd_expire;
  logic cls_accept;
  logic err_set;

  function automatic logic [7:0] idx_to_ascii(input logic [CLS_BW-1:0] idx);
    if (idx < CLS_BW'(26)) return 8'h41 + 8'(idx);
    else                   return 8'h3F;
  endfunction

  assign counting   = (state == S_LOAD) || (state == S_DRAIN) || (state == S_WAIT_CLS);
  assign watching   = (state == S_DRAIN) || (state == S_WAIT_CLS);
  assign any_valid  = i_conv1_valid || i_pool_valid || i_conv2_valid || i_cls_valid;
  assign conv1_full = (conv1_cnt == C1_W'(CONV1_BEATS));
  assign pool_full  = (pool_cnt  == PL_W'(POOL_BEATS));
  assign conv2_full = (conv2_cnt == C2_W'(CONV2_BEATS));
  assign last_pix   = (pix_cnt == PIX_W'(PIX_NUM - 1));
  assign wd_expire  = watching && !any_valid && (wd_cnt == WD_W'(TIMEOUT - 1));
  assign cls_accept = (state == S_WAIT_CLS) && i_cls_valid;

  // Any of these conditions latches the sticky error flag for the current frame.
  assign err_set = (counting && ((i_conv1_valid && conv1_full) ||
                                 (i_pool_valid  && pool_full)  ||
                                 (i_conv2_valid && conv2_full)))
                || (i_cls_valid && (state != S_WAIT_CLS))
                || wd_expire
                || (cls_accept && (i_cls_idx >= CLS_BW'(26)));

  // NOTE: next-state is assigned its hold value first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (i_start) state_nxt = S_CLEAR;
      S_CLEAR:    state_nxt = S_LOAD;
      S_LOAD:     if (last_pix) state_nxt = S_DRAIN;
      S_DRAIN: begin
        if (wd_expire)                                state_nxt = S_DONE;
        else if (conv1_full && pool_full && conv2_full) state_nxt = S_WAIT_CLS;
      end
      S_WAIT_CLS: if (i_cls_valid || wd_expire) state_nxt = S_DONE;
      S_DONE:     state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // NOTE: all registers below use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      img_sel     <= '0;
      pix_cnt     <= '0;
      rom_addr    <= '0;
      pix_valid   <= 1'b0;
      conv1_cnt   <= '0;
      pool_cnt    <= '0;
      conv2_cnt   <= '0;
      wd_cnt      <= '0;
      error_q     <= 1'b0;
      out_valid_q <= 1'b0;
      alpha_q     <= '0;
    end else begin
      state       <= state_nxt;
      pix_valid   <= (state == S_LOAD);
      out_valid_q <= (state_nxt == S_DONE);

      if ((state == S_IDLE) && i_start) img_sel <= sw;

      if (state == S_CLEAR) begin
        pix_cnt  <= '0;
        rom_addr <= ADDR_W'(img_sel) * ADDR_W'(PIX_NUM);
      end else if ((state == S_LOAD) && !last_pix) begin
        pix_cnt  <= pix_cnt + 1'b1;
        rom_addr <= rom_addr + 1'b1;
      end

      if (state == S_CLEAR) begin
        conv1_cnt <= '0;
        pool_cnt  <= '0;
        conv2_cnt <= '0;
      end else if (counting) begin
        if (i_conv1_valid && !conv1_full) conv1_cnt <= conv1_cnt + 1'b1;
        if (i_pool_valid  && !pool_full)  pool_cnt  <= pool_cnt  + 1'b1;
        if (i_conv2_valid && !conv2_full) conv2_cnt <= conv2_cnt + 1'b1;
      end

      // Watchdog measures consecutive cycles without any datapath activity.
      if (!watching || any_valid) wd_cnt <= '0;
      else                        wd_cnt <= wd_cnt + 1'b1;

      if (err_set)                           error_q <= 1'b1;
      else if ((state == S_IDLE) && i_start) error_q <= 1'b0;

      if (state_nxt == S_DONE) alpha_q <= cls_accept ? idx_to_ascii(i_cls_idx) : 8'h3F;
    end
  end

  assign o_rom_addr  = rom_addr;
  assign o_dp_clear  = (state == S_CLEAR);
  assign o_pix_valid = pix_valid;
  assign o_pixel     = pix_valid ? i_rom_data : '0;
  assign o_busy      = (state != S_IDLE);
  assign out_valid   = out_valid_q;
  assign alpha       = alpha_q;
  assign o_error     = error_q;

endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// Self-checking bench for cnn_frame_sequencer: randomized datapath beat timing against
// a frame-level timing model derived from the cycle-numbered behaviour of the block.
module tb_cnn_frame_sequencer;

  localparam int PIX   = 784;
  localparam int DEPTH = 16 * PIX;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_start;
  logic [3:0]  sw;
  logic [13:0] o_rom_addr;
  logic [7:0]  i_rom_data;
  logic        o_dp_clear;
  logic        o_pix_valid;
  logic [7:0]  o_pixel;
  logic        i_conv1_valid;
  logic        i_pool_valid;
  logic        i_conv2_valid;
  logic        i_cls_valid;
  logic [4:0]  i_cls_idx;
  logic        o_busy;
  logic        out_valid;
  logic [7:0]  alpha;
  logic        o_error;

  logic [7:0]  rom [DEPTH];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) i_rom_data <= rom[o_rom_addr];

  cnn_frame_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .i_start      (i_start),
    .sw           (sw),
    .o_rom_addr   (o_rom_addr),
    .i_rom_data   (i_rom_data),
    .o_dp_clear   (o_dp_clear),
    .o_pix_valid  (o_pix_valid),
    .o_pixel      (o_pixel),
    .i_conv1_valid(i_conv1_valid),
    .i_pool_valid (i_pool_valid),
    .i_conv2_valid(i_conv2_valid),
    .i_cls_valid  (i_cls_valid),
    .i_cls_idx    (i_cls_idx),
    .o_busy       (o_busy),
    .out_valid    (out_valid),
    .alpha        (alpha),
    .o_error      (o_error)
  );

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_start       = 1'b0;
    i_conv1_valid = 1'b0;
    i_pool_valid  = 1'b0;
    i_conv2_valid = 1'b0;
    i_cls_valid   = 1'b0;
    i_cls_idx     = 5'($urandom);
    reset         = 1'b0;
  endtask

  // One frame. Cycle 0 is the cycle whose closing edge samples i_start.
  // cls_en=0 models a classifier that never answers; reset_at>=0 asserts reset in that cycle.
  task automatic run_frame(input logic [3:0] sel, input int c2_beats, input bit cls_en,
                           input logic [4:0] idx, input bit load_start, input bit done_start,
                           input int reset_at);
    int   c = 0;
    int   base = int'(sel) * PIX;
    int   c1_left = 576, pl_left = 144, c2_left = c2_beats;
    int   last = 0, cls_cycle = -1, exp_done = 1 << 30, settle;
    bit   beats_done = 1'b0;
    bit   exp_err;
    logic [7:0] exp_alpha;

    exp_err   = (c2_beats > 64) || !cls_en || (idx >= 5'd26);
    exp_alpha = (cls_en && idx < 5'd26) ? 8'h41 + 8'(idx) : 8'h3F;

    i_start = 1'b1;
    sw      = sel;
    while (1) begin
      tick();
      c++;
      idle_inputs();

      if (reset_at >= 0 && c > reset_at) begin
        check("rst_pix_valid", o_pix_valid, 0);
        check("rst_busy", o_busy, 0);
        check("rst_out_valid", out_valid, 0);
        if (c == reset_at + 1) begin
          check("rst_rom_addr", o_rom_addr, 0);
          check("rst_alpha", alpha, 0);
        end
        if (c == reset_at + 4) break;
        continue;
      end

      check("dp_clear", o_dp_clear, c == 1);
      if (c >= 2 && c <= 785) check("rom_addr", o_rom_addr, base + c - 2);
      check("pix_valid", o_pix_valid, c >= 3 && c <= 786);
      if (c >= 3 && c <= 786) check("pixel", o_pixel, rom[base + c - 3]);
      if (c == 1) check("error_cleared", o_error, 0);
      check("busy", o_busy, c <= exp_done);
      check("out_valid", out_valid, c == exp_done);
      if (c == exp_done) begin
        check("alpha", alpha, exp_alpha);
        check("error_at_done", o_error, exp_err);
      end
      if (c == exp_done + 1) begin
        check("alpha_held", alpha, exp_alpha);
        break;
      end
      if (c > 6000) begin
        check("frame_budget", c, exp_done);
        break;
      end

      if (load_start && c == 400) i_start = 1'b1;
      if (done_start && c == exp_done) i_start = 1'b1;
      if (reset_at >= 0 && c == reset_at) reset = 1'b1;

      if (reset_at < 0 || c < reset_at) begin
        if (c >= 150 && c1_left > 0 && $urandom_range(3) != 0) begin
          i_conv1_valid = 1'b1; c1_left--; last = c;
        end
        if (c >= 300 && pl_left > 0 && $urandom_range(1) != 0) begin
          i_pool_valid = 1'b1; pl_left--; last = c;
        end
        if (c >= 500 && c2_left > 0 && $urandom_range(1) != 0) begin
          i_conv2_valid = 1'b1; c2_left--; last = c;
        end
        if (!beats_done && c1_left == 0 && pl_left == 0 && c2_left == 0) begin
          beats_done = 1'b1;
          settle = (last > 785) ? last : 785;
          if (cls_en) cls_cycle = settle + 2 + int'($urandom_range(19));
          else        exp_done  = settle + 4097;
        end
        if (c == cls_cycle) begin
          i_cls_valid = 1'b1;
          i_cls_idx   = idx;
          exp_done    = c + 1;
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) rom[i] = 8'($urandom);
    idle_inputs();
    sw    = 4'd0;
    reset = 1'b1;
    tick();
    tick();
    check("reset_rom_addr", o_rom_addr, 0);
    check("reset_dp_clear", o_dp_clear, 0);
    check("reset_pix_valid", o_pix_valid, 0);
    check("reset_pixel", o_pixel, 0);
    check("reset_busy", o_busy, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_alpha", alpha, 0);
    check("reset_error", o_error, 0);
    reset = 1'b0;
    tick();

    run_frame(4'd0, 64, 1'b1, 5'($urandom_range(25)), 1'b0, 1'b0, -1);
    run_frame(4'd3, 64, 1'b1, 5'd7, 1'b0, 1'b0, -1);
    run_frame(4'($urandom), 65, 1'b1, 5'($urandom_range(25)), 1'b0, 1'b0, -1);
    run_frame(4'($urandom), 64, 1'b1, 5'($urandom_range(25)), 1'b0, 1'b0, -1);

    i_cls_valid = 1'b1;
    tick();
    idle_inputs();
    check("stray_cls_error", o_error, 1);
    check("stray_cls_busy", o_busy, 0);
    check("stray_cls_out_valid", out_valid, 0);

    run_frame(4'd5, 64, 1'b0, 5'd0, 1'b0, 1'b0, -1);
    run_frame(4'd9, 64, 1'b1, 5'($urandom), 1'b1, 1'b1, -1);
    run_frame(4'd2, 64, 1'b1, 5'($urandom_range(25)), 1'b0, 1'b0, 402);
    run_frame(4'd1, 64, 1'b1, 5'($urandom), 1'b0, 1'b0, -1);
    run_frame(4'd15, 64, 1'b1, 5'($urandom_range(26, 31)), 1'b0, 1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cnn_frame_sequencer.md
Name: cnn_frame_sequencer

Overview:
- Top-level sequencer for the CNN classifier pipeline: conv1 5x5 1->3, 2x2 pool, conv2 3->3, then FC/argmax.
- On a start pulse it clears the datapath and streams one 28x28 image from the image ROM, selected by switches, into conv1 at one pixel per clock.
- It counts each stage's output beats to track progress, waits for the classifier result, and emits an ASCII letter with a one-cycle valid.
- A watchdog and a beat-count check flag a stalled or misbehaving datapath.

Parameters:
- IX, 28, image width in pixels.
- IY, 28, image height in pixels.
- I_F_BW, 8, pixel width in bits.
- IMG_NUM, 16, number of images stored in the ROM.
- CONV1_BEATS, 576, expected conv1 output beats per frame (24x24).
- POOL_BEATS, 144, expected pool output beats per frame (12x12).
- CONV2_BEATS, 64, expected conv2 output beats per frame (8x8).
- CLS_BW, 5, width of the class index.
- TIMEOUT, 4096, watchdog limit in cycles without progress.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- i_start  in  1  start pulse; sampled only in IDLE.
- sw  in  4  image select; latched when start is accepted.
- o_rom_addr  out  $clog2(IMG_NUM*IX*IY)  image ROM address. The ROM is synchronous with a 1-cycle read latency.
- i_rom_data  in  I_F_BW  ROM read data.
- o_dp_clear  out  1  one-cycle datapath clear (line buffers, accumulators).
- o_pix_valid  out  1  pixel valid to conv1.
- o_pixel  out  I_F_BW  pixel to conv1.
- i_conv1_valid  in  1  conv1 output beat.
- i_pool_valid  in  1  pool output beat.
- i_conv2_valid  in  1  conv2 output beat.
- i_cls_valid  in  1  classifier result strobe.
- i_cls_idx  in  CLS_BW  classifier argmax index.
- o_busy  out  1  high outside IDLE.
- out_valid  out  1  one-cycle result pulse.
- alpha  out  8  ASCII result; held until the next result.
- o_error  out  1  sticky error; cleared by reset or by an accepted start.

Behaviour:
- Reset values: all outputs 0, state IDLE, all counters 0.
- States:
  - IDLE: on i_start -> CLEAR; latch sw; clear o_error.
  - CLEAR: o_dp_clear=1 for exactly this cycle; address counter set to sw*IX*IY -> LOAD.
  - LOAD: drive o_rom_addr = base+k for k=0..IX*IY-1, one per cycle. o_pix_valid and o_pixel = i_rom_data are registered and appear one cycle after their address. After the last address -> DRAIN.
  - DRAIN: wait until the conv1, pool and conv2 counters all reach their expected values -> WAIT_CLS.
  - WAIT_CLS: on i_cls_valid -> DONE.
  - DONE: out_valid=1 for one cycle -> IDLE.
- Pixel stream:
  - With start sampled at cycle 0: CLEAR at cycle 1, address 0 at cycle 2, first o_pix_valid at cycle 3, last o_pix_valid at cycle 786.
  - o_pix_valid is contiguous, with no gaps.
  - The last pixel's valid beat still occurs after the state has left LOAD.
- Stage counters:
  - Reset at CLEAR.
  - Count i_conv1_valid, i_pool_valid and i_conv2_valid during LOAD, DRAIN and WAIT_CLS.
  - Saturate at their expected value.
  - A beat arriving while a counter is already full sets o_error; operation continues.
- Classifier result:
  - A single i_cls_valid in WAIT_CLS captures i_cls_idx.
  - i_cls_valid in any other state sets o_error and is otherwise ignored.
- Watchdog:
  - In DRAIN and WAIT_CLS, a cycle counter is cleared on any input valid and increments otherwise.
  - Reaching TIMEOUT sets o_error and forces DONE with alpha = 0x3F ('?').
- Alpha mapping:
  - idx < 26 -> alpha = 0x41 + idx.
  - idx >= 26 -> 0x3F, and o_error is set.
  - alpha updates in the DONE cycle, coincident with out_valid.
- i_start outside IDLE is ignored, including in the DONE cycle. A start in the first IDLE cycle after DONE is accepted.
- Reset mid-frame: IDLE on the next edge. o_pix_valid drops on that edge; no out_valid is produced.
- o_busy = (state != IDLE).

Test Plan:
1. Reset, then pulse i_start with sw=0 -> o_dp_clear high at cycle 1 only; o_rom_addr 0..783 over cycles 2..785; o_pix_valid high for cycles 3..786 carrying ROM words 0..783.
2. sw=3, with the datapath model producing 576/144/64 beats and then i_cls_valid with idx=7 -> first address 2352; single out_valid with alpha=0x48 ('H'); o_error=0; o_busy low the following cycle.
3. Same as 2 but the model emits 65 conv2 beats -> o_error=1; the result is still delivered. A new start clears o_error.
4. Model never asserts i_cls_valid -> 4096 idle cycles after the last beat, out_valid pulses with alpha=0x3F and o_error=1.
5. i_start pulsed during LOAD and during DONE -> ignored; address sequence undisturbed; exactly one out_valid.
6. reset asserted at pixel 400 -> o_pix_valid 0 and o_busy 0 after that edge; a fresh start with sw=1 streams addresses from 784.
